// File: rtl/round_controller.sv
// Game-flow master for two-player Tron: title, countdown, play, round-over and game-over sequencing.
// Optional PAUSE state and pause_btn port are built in when PAUSE_EN is defined.
//
// state        | meaning
// TITLE (1)    | idle, scores held clear, waiting for start press
// COUNTDOWN (2)| bikes frozen, countdown digit steps down every COUNT_FRAMES ticks
// PLAY (3)     | bikes move, first crash ends the round
// ROUND_OVER(4)| winner shown, score block settles, timed by ROUND_OVER_FRAMES
// GAME_OVER (5)| a player reached winning score, start press returns to TITLE
// PAUSE (6)    | PAUSE_EN only: play suspended, crashes ignored
module round_controller #(
  parameter int COUNT_FRAMES      = 60,
  parameter int COUNT_STEPS       = 3,
  parameter int ROUND_OVER_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_btn,
  input  logic       crash_blue,
  input  logic       crash_red,
  input  logic       Blue_W,
  input  logic       Red_W,
`ifdef PAUSE_EN
  input  logic       pause_btn,
`endif
  output logic [2:0] Game_State,
  output logic       Reset_Score,
  output logic       reset_round,
  output logic       point_blue,
  output logic       point_red,
  output logic [1:0] round_winner,
  output logic [1:0] countdown,
  output logic       freeze
);

  localparam int MAX_FRAMES = (COUNT_FRAMES > ROUND_OVER_FRAMES) ? COUNT_FRAMES : ROUND_OVER_FRAMES;
  localparam int FW = $clog2(MAX_FRAMES + 1);
  localparam logic [FW-1:0] CD_LAST = FW'(COUNT_FRAMES - 1);
  localparam logic [FW-1:0] RO_LAST = FW'(ROUND_OVER_FRAMES - 1);
  localparam logic [1:0] STEPS_INIT = 2'(COUNT_STEPS);

  typedef enum logic [2:0] {
    S_TITLE      = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_PLAY       = 3'd3,
    S_ROUND_OVER = 3'd4,
    S_GAME_OVER  = 3'd5,
    S_PAUSE      = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] countdown_q, countdown_d;
  logic [1:0] winner_q, winner_d;
  logic reset_round_q, reset_round_d;
  logic point_blue_q, point_blue_d;
  logic point_red_q, point_red_d;
  logic reset_score_q, reset_score_d;
  logic freeze_q, freeze_d;

  // Two sync flops plus one history flop per async input for rising-edge detection
  logic [2:0] frame_sync_q, frame_sync_d;
  logic [2:0] start_sync_q, start_sync_d;
  logic frame_tick, start_press;
`ifdef PAUSE_EN
  logic [2:0] pause_sync_q, pause_sync_d;
  logic pause_press;
`endif

  always_comb begin
    frame_sync_d = {frame_sync_q[1:0], frame_clk};
    start_sync_d = {start_sync_q[1:0], start_btn};
    frame_tick   = frame_sync_q[1] & ~frame_sync_q[2];
    start_press  = start_sync_q[1] & ~start_sync_q[2];
`ifdef PAUSE_EN
    pause_sync_d = {pause_sync_q[1:0], pause_btn};
    pause_press  = pause_sync_q[1] & ~pause_sync_q[2];
`endif
  end

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    countdown_d   = countdown_q;
    winner_d      = winner_q;
    reset_round_d = 1'b0;
    point_blue_d  = 1'b0;
    point_red_d   = 1'b0;

    case (state_q)
      S_TITLE: begin
        if (start_press) begin
          state_d       = S_COUNTDOWN;
          reset_round_d = 1'b1;
          winner_d      = 2'b00;
          countdown_d   = STEPS_INIT;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == CD_LAST) begin
            frame_cnt_d = '0;
            if (countdown_q == 2'd1) begin
              state_d     = S_PLAY;
              countdown_d = 2'd0;
            end else begin
              countdown_d = countdown_q - 2'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (crash_blue && crash_red) begin
          state_d  = S_ROUND_OVER;
          winner_d = 2'b11;
        end else if (crash_red) begin
          state_d      = S_ROUND_OVER;
          winner_d     = 2'b01;
          point_blue_d = 1'b1;
        end else if (crash_blue) begin
          state_d     = S_ROUND_OVER;
          winner_d    = 2'b10;
          point_red_d = 1'b1;
        end
`ifdef PAUSE_EN
        else if (pause_press) begin
          state_d = S_PAUSE;
        end
`endif
      end
      S_ROUND_OVER: begin
        if (frame_tick) begin
          if (frame_cnt_q == RO_LAST) begin
            if (Blue_W || Red_W) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d       = S_COUNTDOWN;
              reset_round_d = 1'b1;
              winner_d      = 2'b00;
              countdown_d   = STEPS_INIT;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_GAME_OVER: begin
        if (start_press) state_d = S_TITLE;
      end
`ifdef PAUSE_EN
      S_PAUSE: begin
        if (pause_press) state_d = S_PLAY;
      end
`endif
      default: state_d = S_TITLE;
    endcase

    // Every state starts its interval timing from zero
    if (state_d != state_q) frame_cnt_d = '0;

    reset_score_d = (state_d == S_TITLE);
    freeze_d      = (state_d != S_PLAY);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_TITLE;
      frame_cnt_q   <= '0;
      countdown_q   <= 2'd0;
      winner_q      <= 2'b00;
      reset_round_q <= 1'b0;
      point_blue_q  <= 1'b0;
      point_red_q   <= 1'b0;
      reset_score_q <= 1'b1;
      freeze_q      <= 1'b1;
      frame_sync_q  <= 3'b000;
      start_sync_q  <= 3'b000;
`ifdef PAUSE_EN
      pause_sync_q  <= 3'b000;
`endif
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      countdown_q   <= countdown_d;
      winner_q      <= winner_d;
      reset_round_q <= reset_round_d;
      point_blue_q  <= point_blue_d;
      point_red_q   <= point_red_d;
      reset_score_q <= reset_score_d;
      freeze_q      <= freeze_d;
      frame_sync_q  <= frame_sync_d;
      start_sync_q  <= start_sync_d;
`ifdef PAUSE_EN
      pause_sync_q  <= pause_sync_d;
`endif
    end
  end

  assign Game_State   = state_q;
  assign Reset_Score  = reset_score_q;
  assign reset_round  = reset_round_q;
  assign point_blue   = point_blue_q;
  assign point_red    = point_red_q;
  assign round_winner = winner_q;
  assign countdown    = countdown_q;
  assign freeze       = freeze_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: full rounds with red win, draw and blue win, game over,
// start-edge handling and mid-round reset; pause path exercised when PAUSE_EN is defined.
module tb_round_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       start_btn = 1'b0;
  logic       crash_blue = 1'b0;
  logic       crash_red = 1'b0;
  logic       Blue_W = 1'b0;
  logic       Red_W = 1'b0;
`ifdef PAUSE_EN
  logic       pause_btn = 1'b0;
`endif
  logic [2:0] Game_State;
  logic       Reset_Score;
  logic       reset_round;
  logic       point_blue;
  logic       point_red;
  logic [1:0] round_winner;
  logic [1:0] countdown;
  logic       freeze;

  int total = 0;
  int bad = 0;
  int n_rr = 0;
  int n_pb = 0;
  int n_pr = 0;

  round_controller #(
    .COUNT_FRAMES(2),
    .COUNT_STEPS(3),
    .ROUND_OVER_FRAMES(120)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .start_btn(start_btn),
    .crash_blue(crash_blue),
    .crash_red(crash_red),
    .Blue_W(Blue_W),
    .Red_W(Red_W),
`ifdef PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .Game_State(Game_State),
    .Reset_Score(Reset_Score),
    .reset_round(reset_round),
    .point_blue(point_blue),
    .point_red(point_red),
    .round_winner(round_winner),
    .countdown(countdown),
    .freeze(freeze)
  );

  always #10 Clk = ~Clk;

  // Pulse widths are counted in cycles, so a 1-cycle pulse adds exactly one
  always @(negedge Clk) begin
    if (reset_round) n_rr++;
    if (point_blue) n_pb++;
    if (point_red) n_pr++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      cyc(4);
      frame_clk = 1'b0;
      cyc(4);
    end
  endtask

  task automatic press_start(input int len);
    start_btn = 1'b1;
    cyc(len);
    start_btn = 1'b0;
    cyc(4);
  endtask

`ifdef PAUSE_EN
  task automatic press_pause();
    pause_btn = 1'b1;
    cyc(6);
    pause_btn = 1'b0;
    cyc(4);
  endtask
`endif

  initial begin
    cyc(2);
    chk("rst_state", Game_State, 1);
    chk("rst_reset_score", Reset_Score, 1);
    chk("rst_freeze", freeze, 1);
    chk("rst_pulses", {reset_round, point_blue, point_red}, 0);
    chk("rst_winner", round_winner, 0);
    chk("rst_countdown", countdown, 0);
    Reset = 1'b0;
    cyc(3);
    chk("idle_title", Game_State, 1);

    // Start held long: one press, one reset_round
    press_start(20);
    chk("cd_state", Game_State, 2);
    chk("cd_reset_round", n_rr, 1);
    chk("cd_digit3", countdown, 3);
    chk("cd_reset_score", Reset_Score, 0);
    chk("cd_freeze", freeze, 1);
    ticks(2);
    chk("cd_digit2", countdown, 2);
    ticks(2);
    chk("cd_digit1", countdown, 1);
    crash_red = 1'b1;
    cyc(5);
    crash_red = 1'b0;
    ticks(1);
    chk("cd_half_step", countdown, 1);
    chk("cd_crash_ignored", n_pb, 0);
    chk("cd_still_cd", Game_State, 2);
    ticks(1);
    chk("play_state", Game_State, 3);
    chk("play_countdown", countdown, 0);
    chk("play_freeze", freeze, 0);

    // Red crash held: single point for blue
    crash_red = 1'b1;
    cyc(50);
    crash_red = 1'b0;
    chk("r1_point_blue", n_pb, 1);
    chk("r1_point_red", n_pr, 0);
    chk("r1_winner", round_winner, 1);
    chk("r1_state", Game_State, 4);
    chk("r1_freeze", freeze, 1);
    ticks(119);
    chk("r1_ro_hold", Game_State, 4);
    ticks(1);
    chk("r1_next_cd", Game_State, 2);
    chk("r1_reset_round", n_rr, 2);
    chk("r1_digit", countdown, 3);
    ticks(6);
    chk("r2_play", Game_State, 3);

    // Simultaneous crash: draw, no points
    crash_blue = 1'b1;
    crash_red = 1'b1;
    cyc(3);
    crash_blue = 1'b0;
    crash_red = 1'b0;
    chk("r2_winner_draw", round_winner, 3);
    chk("r2_state", Game_State, 4);
    chk("r2_points", n_pb + n_pr, 1);
    ticks(120);
    chk("r2_next_cd", Game_State, 2);
    chk("r2_reset_round", n_rr, 3);
    ticks(6);
    chk("r3_play", Game_State, 3);

`ifdef PAUSE_EN
    press_pause();
    chk("pause_state", Game_State, 6);
    chk("pause_freeze", freeze, 1);
    crash_red = 1'b1;
    cyc(5);
    crash_red = 1'b0;
    chk("pause_crash_state", Game_State, 6);
    chk("pause_crash_pts", n_pb, 1);
    press_pause();
    chk("resume_state", Game_State, 3);
    chk("resume_freeze", freeze, 0);
`endif

    // Blue crash: point for red, then red reaches winning score
    crash_blue = 1'b1;
    cyc(10);
    crash_blue = 1'b0;
    chk("r3_point_red", n_pr, 1);
    chk("r3_point_blue", n_pb, 1);
    chk("r3_winner", round_winner, 2);
    chk("r3_state", Game_State, 4);
    Red_W = 1'b1;
    ticks(120);
    chk("go_state", Game_State, 5);
    chk("go_no_reset_round", n_rr, 3);
    chk("go_freeze", freeze, 1);

    // Held start returns to TITLE only, no second trigger into COUNTDOWN
    press_start(20);
    Red_W = 1'b0;
    chk("go_to_title", Game_State, 1);
    chk("title_reset_score", Reset_Score, 1);
    chk("title_no_rr", n_rr, 3);

    press_start(6);
    chk("new_game_cd", Game_State, 2);
    chk("new_game_rr", n_rr, 4);
    Reset = 1'b1;
    cyc(1);
    chk("abort_state", Game_State, 1);
    chk("abort_countdown", countdown, 0);
    chk("abort_reset_score", Reset_Score, 1);
    Reset = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
